// File: rtl/score_ram_arbiter_pkg.sv
// Shared types and helpers for the score RAM arbiter: FSM state encoding,
// scan counter width and the shadow-table slot indexing function.
package score_arb_pkg;

    localparam int DEF_SCAN_DIV = 1024;
    localparam int SCAN_CNT_W   = $clog2(DEF_SCAN_DIV);

    typedef enum logic [3:0] {
        IDLE,
        SC_RD,
        SC_WAIT,
        SC_CAP,
        CM_RD,
        CM_WAIT,
        CM_CMP,
        CM_WR,
        CM_DONE,
        CL_WR,
        CL_DONE
    } arb_state_e;

    // Lowest bit of a slot inside the flattened score table.
    function automatic int slot_lsb(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/score_ram_arbiter_if.sv
// Request, RAM and status bundle of the score RAM arbiter.
// The arbiter uses the slave modport; requesters and the RAM sit on master.
interface score_ram_arbiter_if #(
    parameter int NUM_USERS = 6,
    parameter int SCORE_W   = 8,
    parameter int ADDR_W    = 3
);
    logic                         commit_req;
    logic [ADDR_W-1:0]            commit_user;
    logic [SCORE_W-1:0]           commit_score;
    logic                         commit_ack;
    logic                         commit_err;
    logic                         clear_req;
    logic                         clear_ack;
    logic                         busy;
    logic [ADDR_W-1:0]            ram_addr;
    logic [SCORE_W-1:0]           ram_wdata;
    logic                         ram_we;
    logic                         ram_re;
    logic [SCORE_W-1:0]           ram_rdata;
    logic [NUM_USERS*SCORE_W-1:0] score_table;

    modport master (
        output commit_req, commit_user, commit_score, clear_req, ram_rdata,
        input  commit_ack, commit_err, clear_ack, busy,
               ram_addr, ram_wdata, ram_we, ram_re, score_table
    );

    modport slave (
        input  commit_req, commit_user, commit_score, clear_req, ram_rdata,
        output commit_ack, commit_err, clear_ack, busy,
               ram_addr, ram_wdata, ram_we, ram_re, score_table
    );
endinterface

// File: rtl/score_ram_arbiter_scan_timer.sv
// Free-running SCAN_DIV period counter raising a sticky scan_pend strobe
// that is dropped when the arbiter starts the scan read.
module scan_timer
    import score_arb_pkg::*;
#(
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int CNT_W    = SCAN_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic consume_i,
    output logic pend_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             wrap;

    // A new period expiring wins over a consume in the same cycle.
    always_comb begin
        wrap   = (cnt_q == CNT_W'(SCAN_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pend_d = wrap ? 1'b1 : (consume_i ? 1'b0 : pend_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/score_ram_arbiter.sv
// Score RAM arbiter: clear > commit > background scan, with a shadow score table.
// Define SCORE_KEEP_BEST_EN for read-compare-write commits; otherwise last score wins.
module score_ram_arbiter
    import score_arb_pkg::*;
#(
    parameter int NUM_USERS = 6,
    parameter int SCORE_W   = 8,
    parameter int ADDR_W    = 3,
    parameter int READ_LAT  = 1,
    parameter int SCAN_DIV  = DEF_SCAN_DIV
) (
    input  logic              clk,
    input  logic              rst,
    score_ram_arbiter_if.slave bus
);
    arb_state_e                   state_q, state_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [SCORE_W-1:0]           wdata_q, wdata_d;
    logic                         we_q, we_d, re_q, re_d;
    logic                         cm_ack_q, cm_ack_d, cm_err_q, cm_err_d, cl_ack_q, cl_ack_d;
    logic                         cm_lock_q, cm_lock_d, cl_lock_q, cl_lock_d;
    logic [ADDR_W-1:0]            scan_ptr_q, scan_ptr_d;
    logic [NUM_USERS*SCORE_W-1:0] shadow_q, shadow_d;
    logic                         scan_pend, scan_take, user_ok;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    ($clog2(SCAN_DIV))
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .consume_i (scan_take),
        .pend_o    (scan_pend)
    );

    assign user_ok = (int'(bus.commit_user) < NUM_USERS);

    // RAM strobes are registered, so they are decoded from the state being entered.
    // The locks hold off a request that is still high after its ack.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        cm_ack_d   = 1'b0;
        cm_err_d   = 1'b0;
        cl_ack_d   = 1'b0;
        cm_lock_d  = cm_lock_q & bus.commit_req;
        cl_lock_d  = cl_lock_q & bus.clear_req;
        scan_ptr_d = scan_ptr_q;
        shadow_d   = shadow_q;
        scan_take  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear_req && !cl_lock_q) begin
                    state_d  = CL_WR;
                    addr_d   = '0;
                    wdata_d  = '0;
                    we_d     = 1'b1;
                    shadow_d = '0;
                end else if (bus.commit_req && !cm_lock_q) begin
                    if (!user_ok) begin
                        state_d  = CM_DONE;
                        cm_ack_d = 1'b1;
                        cm_err_d = 1'b1;
                    end else begin
                        addr_d = bus.commit_user;
`ifdef SCORE_KEEP_BEST_EN
                        state_d = CM_RD;
                        re_d    = 1'b1;
`else
                        state_d = CM_WR;
                        we_d    = 1'b1;
                        wdata_d = bus.commit_score;
`endif
                    end
                end else if (scan_pend) begin
                    state_d   = SC_RD;
                    addr_d    = scan_ptr_q;
                    re_d      = 1'b1;
                    scan_take = 1'b1;
                end
            end
            SC_RD:   state_d = (READ_LAT > 1) ? SC_WAIT : SC_CAP;
            SC_WAIT: state_d = SC_CAP;
            SC_CAP: begin
                shadow_d[slot_lsb(int'(scan_ptr_q), SCORE_W) +: SCORE_W] = bus.ram_rdata;
                scan_ptr_d = (int'(scan_ptr_q) == NUM_USERS - 1) ? '0 : scan_ptr_q + 1'b1;
                state_d    = IDLE;
            end
            CM_RD:   state_d = (READ_LAT > 1) ? CM_WAIT : CM_CMP;
            CM_WAIT: state_d = CM_CMP;
            CM_CMP: begin
                if (bus.commit_score > bus.ram_rdata) begin
                    state_d = CM_WR;
                    we_d    = 1'b1;
                    wdata_d = bus.commit_score;
                end else begin
                    state_d  = CM_DONE;
                    cm_ack_d = 1'b1;
                end
            end
            CM_WR: begin
                shadow_d[slot_lsb(int'(addr_q), SCORE_W) +: SCORE_W] = wdata_q;
                state_d  = CM_DONE;
                cm_ack_d = 1'b1;
            end
            CM_DONE: begin
                state_d   = IDLE;
                cm_lock_d = 1'b1;
            end
            CL_WR: begin
                if (int'(addr_q) == NUM_USERS - 1) begin
                    state_d  = CL_DONE;
                    cl_ack_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
            CL_DONE: begin
                state_d   = IDLE;
                cl_lock_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            cm_ack_q   <= 1'b0;
            cm_err_q   <= 1'b0;
            cl_ack_q   <= 1'b0;
            cm_lock_q  <= 1'b0;
            cl_lock_q  <= 1'b0;
            scan_ptr_q <= '0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            cm_ack_q   <= cm_ack_d;
            cm_err_q   <= cm_err_d;
            cl_ack_q   <= cl_ack_d;
            cm_lock_q  <= cm_lock_d;
            cl_lock_q  <= cl_lock_d;
            scan_ptr_q <= scan_ptr_d;
            shadow_q   <= shadow_d;
        end
    end

    assign bus.ram_addr    = addr_q;
    assign bus.ram_wdata   = wdata_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_re      = re_q;
    assign bus.commit_ack  = cm_ack_q;
    assign bus.commit_err  = cm_err_q;
    assign bus.clear_ack   = cl_ack_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.score_table = shadow_q;
endmodule

// File: tb/tb_score_ram_arbiter.sv
// Self-checking bench for score_ram_arbiter against a behavioural RAM and score model.
// Honours SCORE_KEEP_BEST_EN the same way the design does.
module tb_score_ram_arbiter;
    localparam int NU = 6;
    localparam int SW = 8;
    localparam int AW = 3;
    localparam int SD = 64;
`ifdef SCORE_KEEP_BEST_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif
    localparam int LAT_WR   = KEEP ? 4 : 2;
    localparam int WE_AT    = KEEP ? 3 : 1;
    localparam int LAT_NOWR = 3;
    localparam int RE_PER   = KEEP ? 1 : 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ref_mem [NU];

    always #5 clk = ~clk;

    score_ram_arbiter_if #(.NUM_USERS(NU), .SCORE_W(SW), .ADDR_W(AW)) bus ();

    score_ram_arbiter #(
        .NUM_USERS (NU),
        .SCORE_W   (SW),
        .ADDR_W    (AW),
        .READ_LAT  (1),
        .SCAN_DIV  (SD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural single-port RAM with one-cycle read latency plus a preload port.
    logic [SW-1:0] mem [0:7];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [SW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    function automatic logic [NU*SW-1:0] pack_ref();
        logic [NU*SW-1:0] v;
        v = '0;
        for (int k = 0; k < NU; k++) v[k*SW +: SW] = SW'(ref_mem[k]);
        return v;
    endfunction

    task automatic preload(input int a, input int d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = AW'(a);
        pre_data = SW'(d);
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (bus.busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("[TB] FAIL wait_idle: busy got %0b required 0", bus.busy);
        end
    endtask

    task automatic run_commit(input int user, input int score, input int hold,
                              output int ack_cyc, output int we_cyc, output int re_cnt,
                              output logic err, output int wa, output int wd, output int extra);
        ack_cyc = 0; we_cyc = 0; re_cnt = 0; err = 1'b0; wa = -1; wd = -1; extra = 0;
        bus.commit_user  = AW'(user);
        bus.commit_score = SW'(score);
        bus.commit_req   = 1'b1;
        for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.ram_we && we_cyc == 0) begin
                we_cyc = c;
                wa     = int'(bus.ram_addr);
                wd     = int'(bus.ram_wdata);
            end
            if (bus.ram_re) re_cnt++;
            if (bus.commit_ack) begin
                ack_cyc = c;
                err     = bus.commit_err;
            end
        end
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (bus.commit_ack) extra++;
        end
        bus.commit_req = 1'b0;
    endtask

    task automatic run_clear(output int ack_cyc, output int nwr, output int bad);
        ack_cyc = 0; nwr = 0; bad = 0;
        bus.clear_req = 1'b1;
        for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.ram_we) begin
                if (int'(bus.ram_addr) != nwr || bus.ram_wdata != 0) bad++;
                nwr++;
            end
            if (bus.clear_ack) ack_cyc = c;
        end
        bus.clear_req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if ({bus.ram_we, bus.ram_re, bus.commit_ack, bus.commit_err, bus.clear_ack, bus.busy} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_strobes: got %b required 000000",
                     {bus.ram_we, bus.ram_re, bus.commit_ack, bus.commit_err, bus.clear_ack, bus.busy});
        end
        checks++;
        if ({bus.ram_addr, bus.ram_wdata} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got %0h required 0", {bus.ram_addr, bus.ram_wdata});
        end
        checks++;
        if (bus.score_table !== '0) begin
            errors++;
            $display("[TB] FAIL reset_table: got %0h required 0", bus.score_table);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: busy got %0b required 0", bus.busy);
        end
    endtask

    task automatic test_commit_write();
        int ack, wec, rec, wa, wd, extra;
        logic err;
        do_reset();
        preload(2, 0);
        wait_idle();
        run_commit(2, 45, 4, ack, wec, rec, err, wa, wd, extra);
        checks++;
        if (wec != WE_AT) begin errors++; $display("[TB] FAIL cw_we_cycle: got %0d required %0d", wec, WE_AT); end
        checks++;
        if (wa != 2 || wd != 45) begin errors++; $display("[TB] FAIL cw_we_data: got addr %0d data %0d required addr 2 data 45", wa, wd); end
        checks++;
        if (ack != LAT_WR) begin errors++; $display("[TB] FAIL cw_ack_cycle: got %0d required %0d", ack, LAT_WR); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL cw_err: got %0b required 0", err); end
        checks++;
        if (rec != RE_PER) begin errors++; $display("[TB] FAIL cw_reads: got %0d required %0d", rec, RE_PER); end
        checks++;
        if (extra != 0) begin errors++; $display("[TB] FAIL cw_reserve: extra acks got %0d required 0", extra); end
        checks++;
        if (bus.score_table[23:16] !== 8'd45) begin errors++; $display("[TB] FAIL cw_shadow: got %0d required 45", bus.score_table[23:16]); end
    endtask

    task automatic test_commit_nowrite();
        int ack, wec, rec, wa, wd, extra, exp_ack, exp_we, exp_slot;
        logic err;
        preload(3, 0);
        wait_idle();
        run_commit(3, 60, 0, ack, wec, rec, err, wa, wd, extra);
        checks++;
        if (ack != LAT_WR) begin errors++; $display("[TB] FAIL cn_first_ack: got %0d required %0d", ack, LAT_WR); end
        wait_idle();
        run_commit(3, 45, 0, ack, wec, rec, err, wa, wd, extra);
        exp_ack  = KEEP ? LAT_NOWR : LAT_WR;
        exp_we   = KEEP ? 0 : WE_AT;
        exp_slot = KEEP ? 60 : 45;
        checks++;
        if (ack != exp_ack) begin errors++; $display("[TB] FAIL cn_ack_cycle: got %0d required %0d", ack, exp_ack); end
        checks++;
        if (wec != exp_we) begin errors++; $display("[TB] FAIL cn_we_cycle: got %0d required %0d", wec, exp_we); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("[TB] FAIL cn_err: got %0b required 0", err); end
        checks++;
        if (int'(bus.score_table[31:24]) != exp_slot) begin errors++; $display("[TB] FAIL cn_shadow: got %0d required %0d", bus.score_table[31:24], exp_slot); end
    endtask

    task automatic test_commit_invalid();
        int ack, wec, rec, wa, wd, extra;
        logic err;
        wait_idle();
        run_commit(7, 99, 0, ack, wec, rec, err, wa, wd, extra);
        checks++;
        if (ack != 1) begin errors++; $display("[TB] FAIL ci_ack_cycle: got %0d required 1", ack); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL ci_err: got %0b required 1", err); end
        checks++;
        if (rec != 0 || wec != 0) begin errors++; $display("[TB] FAIL ci_ram_idle: got reads %0d write cycle %0d required 0 0", rec, wec); end
    endtask

    task automatic test_clear_commit();
        int wcyc[$], wadr[$], wdat[$];
        int clr_cyc, cm_cyc, good;
        logic busy1;
        for (int k = 0; k < NU; k++) preload(k, $urandom_range(1, 255));
        wait_idle();
        clr_cyc = 0; cm_cyc = 0; busy1 = 1'b0;
        bus.clear_req    = 1'b1;
        bus.commit_user  = 3'd1;
        bus.commit_score = 8'd10;
        bus.commit_req   = 1'b1;
        for (int c = 1; c <= 40 && cm_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = bus.busy;
            if (bus.ram_we) begin
                wcyc.push_back(c);
                wadr.push_back(int'(bus.ram_addr));
                wdat.push_back(int'(bus.ram_wdata));
            end
            if (bus.clear_ack) begin clr_cyc = c; bus.clear_req = 1'b0; end
            if (bus.commit_ack) begin cm_cyc = c; bus.commit_req = 1'b0; end
        end
        bus.clear_req  = 1'b0;
        bus.commit_req = 1'b0;
        for (int k = 0; k < NU; k++) ref_mem[k] = 0;
        ref_mem[1] = 10;
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL cc_busy: got %0b required 1", busy1); end
        checks++;
        if (clr_cyc != NU + 1) begin errors++; $display("[TB] FAIL cc_clear_ack: got %0d required %0d", clr_cyc, NU + 1); end
        checks++;
        if (wcyc.size() != NU + 1) begin
            errors++;
            $display("[TB] FAIL cc_write_count: got %0d required %0d", wcyc.size(), NU + 1);
        end else begin
            good = 0;
            for (int k = 0; k < NU; k++)
                if (wcyc[k] == k + 1 && wadr[k] == k && wdat[k] == 0) good++;
            checks++;
            if (good != NU) begin errors++; $display("[TB] FAIL cc_zero_writes: got %0d good required %0d", good, NU); end
            checks++;
            if (wcyc[NU] != NU + 2 + WE_AT || wadr[NU] != 1 || wdat[NU] != 10) begin
                errors++;
                $display("[TB] FAIL cc_commit_write: got cycle %0d addr %0d data %0d required %0d 1 10",
                         wcyc[NU], wadr[NU], wdat[NU], NU + 2 + WE_AT);
            end
        end
        checks++;
        if (cm_cyc != NU + 2 + LAT_WR) begin errors++; $display("[TB] FAIL cc_commit_ack: got %0d required %0d", cm_cyc, NU + 2 + LAT_WR); end
        checks++;
        if (bus.score_table !== pack_ref()) begin errors++; $display("[TB] FAIL cc_table: got %0h required %0h", bus.score_table, pack_ref()); end
    endtask

    task automatic test_scan();
        int rcyc[$], radr[$];
        int good;
        logic [NU*SW-1:0] expv;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NU; k++) preload(k, k + 1);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 9 * SD && rcyc.size() < NU; c++) begin
            @(negedge clk);
            if (bus.ram_re) begin rcyc.push_back(c); radr.push_back(int'(bus.ram_addr)); end
        end
        checks++;
        if (rcyc.size() != NU) begin
            errors++;
            $display("[TB] FAIL sc_read_count: got %0d required %0d", rcyc.size(), NU);
        end else begin
            good = 0;
            for (int k = 0; k < NU; k++)
                if (radr[k] == k && (k == 0 || rcyc[k] - rcyc[k-1] == SD)) good++;
            checks++;
            if (good != NU) begin errors++; $display("[TB] FAIL sc_read_order: got %0d good required %0d", good, NU); end
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NU; k++) expv[k*SW +: SW] = SW'(k + 1);
        checks++;
        if (bus.score_table !== expv) begin errors++; $display("[TB] FAIL sc_table: got %0h required %0h", bus.score_table, expv); end
        preload(0, 99);
        good = -1;
        for (int c = 0; c < 2 * SD && good < 0; c++) begin
            @(negedge clk);
            if (bus.ram_re) good = int'(bus.ram_addr);
        end
        checks++;
        if (good != 0) begin errors++; $display("[TB] FAIL sc_wrap_addr: got %0d required 0", good); end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.score_table[7:0] !== 8'd99) begin errors++; $display("[TB] FAIL sc_wrap_data: got %0d required 99", bus.score_table[7:0]); end
    endtask

    task automatic test_reset_during_write();
        int found, rcyc, radr;
        preload(0, 33);
        preload(4, 0);
        wait_idle();
        bus.commit_user  = 3'd4;
        bus.commit_score = 8'd77;
        bus.commit_req   = 1'b1;
        found = 0;
        for (int c = 1; c <= 20 && found == 0; c++) begin
            @(negedge clk);
            if (bus.ram_we) found = c;
        end
        checks++;
        if (found != WE_AT) begin errors++; $display("[TB] FAIL rw_we_seen: got cycle %0d required %0d", found, WE_AT); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ram_we !== 1'b0) begin errors++; $display("[TB] FAIL rw_we_async: got %0b required 0", bus.ram_we); end
        checks++;
        if ({bus.ram_re, bus.commit_ack, bus.commit_err, bus.clear_ack, bus.busy, bus.ram_addr, bus.ram_wdata} !== '0
            || bus.score_table !== '0) begin
            errors++;
            $display("[TB] FAIL rw_outputs: got busy %0b addr %0d table %0h required all 0", bus.busy, bus.ram_addr, bus.score_table);
        end
        bus.commit_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rw_idle: busy got %0b required 0", bus.busy); end
        rcyc = 0; radr = -1;
        for (int c = 2; c <= 3 * SD && rcyc == 0; c++) begin
            @(negedge clk);
            if (bus.ram_re) begin rcyc = c; radr = int'(bus.ram_addr); end
        end
        checks++;
        if (rcyc != SD + 1 || radr != 0) begin errors++; $display("[TB] FAIL rw_scan: got cycle %0d addr %0d required %0d 0", rcyc, radr, SD + 1); end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.score_table[7:0] !== 8'd33) begin errors++; $display("[TB] FAIL rw_resync: got %0d required 33", bus.score_table[7:0]); end
    endtask

    task automatic test_random();
        int ack, wec, rec, wa, wd, extra, nwr, bad, user, score, exp_ack, exp_we;
        logic err, valid, written;
        wait_idle();
        run_clear(ack, nwr, bad);
        for (int k = 0; k < NU; k++) ref_mem[k] = 0;
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            if ($urandom_range(0, 9) == 0) begin
                run_clear(ack, nwr, bad);
                for (int k = 0; k < NU; k++) ref_mem[k] = 0;
                checks++;
                if (ack != NU + 1 || nwr != NU || bad != 0) begin
                    errors++;
                    $display("[TB] FAIL rnd_clear: got ack %0d writes %0d bad %0d required %0d %0d 0", ack, nwr, bad, NU + 1, NU);
                end
            end else begin
                user  = $urandom_range(0, 7);
                score = $urandom_range(0, 255);
                valid   = (user < NU);
                written = valid && (!KEEP || score > ref_mem[user]);
                exp_ack = !valid ? 1 : (written ? LAT_WR : LAT_NOWR);
                exp_we  = written ? WE_AT : 0;
                run_commit(user, score, 0, ack, wec, rec, err, wa, wd, extra);
                if (written) ref_mem[user] = score;
                checks++;
                if (err !== !valid) begin errors++; $display("[TB] FAIL rnd_err: user %0d got %0b required %0b", user, err, !valid); end
                checks++;
                if (ack != exp_ack) begin errors++; $display("[TB] FAIL rnd_ack: user %0d score %0d got %0d required %0d", user, score, ack, exp_ack); end
                checks++;
                if (wec != exp_we) begin errors++; $display("[TB] FAIL rnd_we: user %0d score %0d got %0d required %0d", user, score, wec, exp_we); end
                if (written) begin
                    checks++;
                    if (wa != user || wd != score) begin errors++; $display("[TB] FAIL rnd_wdata: got %0d/%0d required %0d/%0d", wa, wd, user, score); end
                end
            end
            checks++;
            if (bus.score_table !== pack_ref()) begin errors++; $display("[TB] FAIL rnd_table: got %0h required %0h", bus.score_table, pack_ref()); end
        end
    endtask

    initial begin
        bus.commit_req   = 1'b0;
        bus.commit_user  = '0;
        bus.commit_score = '0;
        bus.clear_req    = 1'b0;
        for (int k = 0; k < 8; k++) preload(k, 0);
        test_reset();
        test_commit_write();
        test_commit_nowrite();
        test_commit_invalid();
        test_clear_commit();
        test_scan();
        test_reset_during_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_ram_arbiter.md
Name: score_ram_arbiter

Overview:
- Owns the single-port per-user score RAM and shares it between two requesters: the game-end score commit path and a background display-refresh scanner.
- Commit performs read-compare-write so that each user slot keeps its best score.
- A clear request zeroes every slot.
- Keeps a shadow table of all user scores for the HEX4/HEX5 decoders, so the decoders no longer read the RAM directly.

Parameters:
- NUM_USERS, 6: number of user slots (addresses 0..NUM_USERS-1).
- SCORE_W, 8: score width in bits.
- ADDR_W, 3: RAM address width; must satisfy 2^ADDR_W >= NUM_USERS.
- READ_LAT, 1: cycles from the ram_re cycle to valid ram_rdata; legal values 1..2.
- SCAN_DIV, 1024: clock cycles between background scan reads; minimum 4.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- commit_req, input, 1: level request; held with its fields stable until commit_ack.
- commit_user, input, ADDR_W: target user slot.
- commit_score, input, SCORE_W: final game score.
- commit_ack, output, 1: one-cycle pulse when the commit completes.
- commit_err, output, 1: one-cycle pulse together with commit_ack when commit_user >= NUM_USERS.
- clear_req, input, 1: level request to zero all slots; held until clear_ack.
- clear_ack, output, 1: one-cycle pulse when the clear completes.
- busy, output, 1: high in any state other than IDLE.
- ram_addr, output, ADDR_W: registered RAM address.
- ram_wdata, output, SCORE_W: registered RAM write data.
- ram_we, output, 1: registered RAM write enable.
- ram_re, output, 1: registered RAM read strobe.
- ram_rdata, input, SCORE_W: RAM read data.
- score_table, output, NUM_USERS*SCORE_W: shadow copy of all slots; slot k occupies bits [k*SCORE_W +: SCORE_W].

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, score_table 0, state IDLE, scan_ptr 0, scan timer 0. ram_we drops immediately. A write in flight is abandoned; the RAM content of that slot is then undefined, and the next scan pass resynchronises the shadow.
- States: IDLE, SC_RD, SC_WAIT, SC_CAP, CM_RD, CM_WAIT, CM_CMP, CM_WR, CM_DONE, CL_WR, CL_DONE.
- Arbitration is evaluated only in IDLE. Fixed priority: clear, then commit, then scan. A lower-priority request stays pending and is not dropped. Sequences that have started are never pre-empted.
- Scan timer: free-running count to SCAN_DIV-1, then sets scan_pend and wraps to 0. scan_pend clears when SC_RD is entered.
- Scan sequence:
  - SC_RD: ram_addr = scan_ptr, ram_re = 1.
  - SC_WAIT: lasts READ_LAT-1 cycles (0 cycles when READ_LAT = 1).
  - SC_CAP: shadow[scan_ptr] <= ram_rdata; scan_ptr increments and wraps from NUM_USERS-1 to 0.
  - Then IDLE.
- Commit sequence:
  - If commit_user >= NUM_USERS: go directly to CM_DONE; the RAM is not accessed; commit_err = 1.
  - CM_RD: read the slot.
  - CM_WAIT: READ_LAT-1 cycles.
  - CM_CMP: if commit_score > ram_rdata (unsigned), go to CM_WR; otherwise go to CM_DONE.
  - CM_WR: ram_we = 1, ram_wdata = commit_score, and the shadow slot is written in the same cycle (write-through).
  - CM_DONE: commit_ack = 1 for one cycle, then IDLE.
  - commit_req must be low for at least one cycle before a new request is accepted; a request still high in the cycle after ack is not re-served.
- Commit latency, READ_LAT = 1, from IDLE with the request seen:
  - 4 cycles to ack when written (CM_RD, CM_CMP, CM_WR, CM_DONE).
  - 3 cycles to ack when not written (CM_RD, CM_CMP, CM_DONE).
- Clear sequence:
  - CL_WR: iterates addresses 0..NUM_USERS-1, one write per cycle with wdata 0; the whole shadow is zeroed on CL_WR entry.
  - CL_DONE: clear_ack pulses. Total NUM_USERS+1 cycles.
  - clear_req must deassert before it is re-served.
- Simultaneous clear and commit: clear runs first and commit is served after it. Because the stored slot is then 0, any non-zero score is written.
- Equal score (commit_score == stored value): no write; ack only.

Optional Feature:
- SCORE_KEEP_BEST_EN defined: CM_CMP compare as described above.
- SCORE_KEEP_BEST_EN undefined:
  - CM_RD, CM_WAIT and CM_CMP are skipped; every valid commit goes IDLE, then CM_WR, then CM_DONE (last-score-wins).
  - Latency is 2 cycles.
  - ram_re is never asserted by the commit path.

Decomposition:
- Package score_arb_pkg holds:
  - the state enum;
  - localparam SCAN_CNT_W = $clog2(SCAN_DIV);
  - a slot-index helper function.
- One natural sub-module, scan_timer: the SCAN_DIV counter producing the scan_pend strobe with clear-on-consume. Everything else stays flat.

Test Plan:
- Reset, then a commit with user 2, score 8'd45, RAM slot = 0 → ram_we at cycle 3 with addr 2 and data 45; ack at cycle 4; score_table[23:16] = 45.
- Stored value 60, commit score 45 → no ram_we; ack at cycle 3; commit_err = 0; shadow unchanged at 60.
- Commit with user 7 → ack and commit_err together in the cycle after acceptance; no ram_re or ram_we observed.
- clear_req and commit_req (user 1, score 10) raised in the same cycle → 6 zero writes to addresses 0..5 and clear_ack, then the commit writes 10 to address 1 and acks.
- Preload RAM with 1..6 and use SCAN_DIV = 4 → after 6 scan periods score_table equals {6,5,4,3,2,1}; scan_ptr wraps to 0.
- Drive rst low during CM_WR → ram_we falls without waiting for a clock edge; all outputs are 0; after release the FSM is IDLE and the next scan behaves normally.
